// File: rtl/uart_systolic_ctrl.sv
// Byte-stream controller for an NxN systolic array: loads A/B operands from a headered
// UART frame, gathers N*N results and returns each as three big-endian bytes.
module uart_systolic_ctrl #(
  parameter int         N       = 2,
  parameter int         DW      = 8,
  parameter int         RW      = 21,
  parameter logic [7:0] HDR     = 8'hA5,
  parameter int         TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  output logic          arr_clr,
  output logic [DW-1:0] arr_data,
  output logic          arr_valid,
  input  logic [RW-1:0] res_data,
  input  logic          res_valid,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_done,
  output logic          busy,
  output logic          frame_done,
  output logic          err_timeout,
  output logic [7:0]    drop_cnt
);
  localparam int NN         = N * N;
  localparam int LOAD_BYTES = 2 * NN;
  localparam int LW         = $clog2(LOAD_BYTES + 1);
  localparam int IW         = (NN > 1) ? $clog2(NN) : 1;
  localparam int TW         = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, SEND} state_t;
  state_t state, state_nxt;

  logic [LW-1:0] load_cnt;
  logic [IW-1:0] wr_ptr;
  logic [IW-1:0] rd_ptr;
  logic [1:0]    byte_sel;
  logic [TW-1:0] idle_cnt;
  logic          tx_pending;
  logic [RW-1:0] res_buf [NN];

  logic          hdr_hit, load_fire, res_fire, timeout_hit;
  logic          tx_issue, tx_ack, tx_last, drop_fire;
  logic [23:0]   cur_res;
  logic [7:0]    cur_byte;

  assign busy    = (state != IDLE);
  assign tx_last = (rd_ptr == IW'(NN - 1)) && (byte_sel == 2'd2);
  assign cur_res = 24'(res_buf[rd_ptr]);

  // Results narrower than 24 bits are zero-padded in the leading byte.
  always_comb begin
    cur_byte = cur_res[7:0];
    case (byte_sel)
      2'd0:    cur_byte = cur_res[23:16];
      2'd1:    cur_byte = cur_res[15:8];
      default: cur_byte = cur_res[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    hdr_hit     = 1'b0;
    load_fire   = 1'b0;
    res_fire    = 1'b0;
    timeout_hit = 1'b0;
    tx_issue    = 1'b0;
    tx_ack      = 1'b0;
    drop_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_done) begin
          if (rx_data == HDR) begin
            hdr_hit   = 1'b1;
            state_nxt = LOAD;
          end else begin
            drop_fire = 1'b1;
          end
        end
      end
      LOAD: begin
        if (rx_done) begin
          load_fire = 1'b1;
          if (load_cnt == LW'(LOAD_BYTES - 1)) state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        drop_fire = rx_done;
        if (res_valid) begin
          res_fire = 1'b1;
          if (wr_ptr == IW'(NN - 1)) state_nxt = SEND;
        end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      SEND: begin
        drop_fire = rx_done;
        if (!tx_pending) begin
          tx_issue = 1'b1;
        end else if (tx_done) begin
          tx_ack = 1'b1;
          if (tx_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arr_clr     <= 1'b0;
      arr_valid   <= 1'b0;
      arr_data    <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      drop_cnt    <= '0;
      load_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      byte_sel    <= '0;
      idle_cnt    <= '0;
      tx_pending  <= 1'b0;
      for (int i = 0; i < NN; i++) res_buf[i] <= '0;
    end else begin
      arr_clr     <= hdr_hit;
      arr_valid   <= load_fire;
      tx_start    <= tx_issue;
      frame_done  <= tx_ack && tx_last;
      err_timeout <= timeout_hit;

      if (load_fire) arr_data <= DW'(rx_data);
      if (drop_fire && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

      if (hdr_hit)        load_cnt <= '0;
      else if (load_fire) load_cnt <= load_cnt + 1'b1;

      // A timeout simply abandons the buffer; the write pointer restarts on the next frame.
      if (state != COMPUTE) begin
        wr_ptr   <= '0;
        idle_cnt <= '0;
      end else if (res_fire) begin
        res_buf[wr_ptr] <= res_data;
        wr_ptr          <= wr_ptr + 1'b1;
        idle_cnt        <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (state != SEND) begin
        rd_ptr     <= '0;
        byte_sel   <= '0;
        tx_pending <= 1'b0;
      end else begin
        if (tx_issue) begin
          tx_data    <= cur_byte;
          tx_pending <= 1'b1;
        end
        if (tx_ack) begin
          tx_pending <= 1'b0;
          if (byte_sel == 2'd2) begin
            byte_sel <= '0;
            rd_ptr   <= rd_ptr + 1'b1;
          end else begin
            byte_sel <= byte_sel + 2'd1;
          end
        end
      end
    end
  end

endmodule
